// File: rtl/lsu_mem_adapter_if.sv
// Core load/store request/response channel plus the data-memory port of lsu_mem_adapter.
// slave = adapter view, master = core/memory (environment) view.
interface lsu_mem_adapter_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/lsu_mem_adapter.sv
// Load/store unit to word-organised data memory adapter with sub-word read-modify-write.
// Build option: define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning down.
module lsu_mem_adapter #(
    parameter int ADDR_WORDS = 256
) (
    input  logic             clk,
    input  logic             rst,
    lsu_mem_adapter_if.slave bus
);
    localparam logic [31:0] WORD_LIMIT = 32'(ADDR_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic        we_r;
    logic [1:0]  size_r;
    logic        unsigned_r;
    logic [1:0]  lane_r;
    logic [29:0] widx_r;
    logic [31:0] wdata_r;
    logic [31:0] rdata_r;
    logic        err_r;
    logic        misalign_s;
    logic        illegal_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic zext);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   res = zext ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   res = zext ? {16'h0000, h} : {{16{h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] res;
        res = old;
        case (size)
            2'b00: begin
                case (lane)
                    2'd0:    res[7:0]   = data[7:0];
                    2'd1:    res[15:8]  = data[7:0];
                    2'd2:    res[23:16] = data[7:0];
                    default: res[31:24] = data[7:0];
                endcase
            end
            2'b01: begin
                if (lane[1]) res[31:16] = data[15:0];
                else         res[15:0]  = data[15:0];
            end
            default: res = data;
        endcase
        return res;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    // Misaligned half/word accesses fault.
    always_comb begin
        if (bus.req_size == 2'b01)      misalign_s = bus.req_addr[0];
        else if (bus.req_size == 2'b10) misalign_s = (bus.req_addr[1:0] != 2'b00);
        else                            misalign_s = 1'b0;
    end
`else
    assign misalign_s = 1'b0;
`endif

    assign illegal_s = (bus.req_size == 2'b11)
                     || ({2'b00, bus.req_addr[31:2]} >= WORD_LIMIT)
                     || misalign_s;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // Next-state logic; only word stores skip the read phase.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (!bus.req_valid)                          state_s = ST_IDLE;
                else if (illegal_s)                          state_s = ST_DONE;
                else if (bus.req_we && bus.req_size == 2'b10) state_s = ST_WRITE;
                else                                         state_s = ST_READ;
            end
            ST_READ: begin
                if (we_r) state_s = ST_WRITE;
                else      state_s = ST_DONE;
            end
            ST_WRITE: state_s = ST_DONE;
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state and registered datapath only.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.resp_rdata = rdata_r;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = 32'h0000_0000;
        bus.mem_wdata  = 32'h0000_0000;
        case (state_r)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_READ: bus.mem_addr  = {2'b00, widx_r};
            ST_WRITE: begin
                bus.mem_we    = 1'b1;
                bus.mem_addr  = {2'b00, widx_r};
                bus.mem_wdata = wdata_r;
            end
            ST_DONE: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = err_r;
            end
            default: bus.req_ready = 1'b0;
        endcase
    end

    // Request latch, read capture/merge and response data; resp data changes only on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_r       <= 1'b0;
            size_r     <= 2'b00;
            unsigned_r <= 1'b0;
            lane_r     <= 2'b00;
            widx_r     <= 30'h0;
            wdata_r    <= 32'h0000_0000;
            rdata_r    <= 32'h0000_0000;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_r       <= bus.req_we;
                        size_r     <= bus.req_size;
                        unsigned_r <= bus.req_unsigned;
                        lane_r     <= bus.req_addr[1:0];
                        widx_r     <= bus.req_addr[31:2];
                        wdata_r    <= bus.req_wdata;
                        err_r      <= illegal_s;
                        if (illegal_s) rdata_r <= 32'h0000_0000;
                    end
                end
                ST_READ: begin
                    if (we_r) wdata_r <= store_merge(bus.mem_rdata, wdata_r, size_r, lane_r);
                    else      rdata_r <= load_extract(bus.mem_rdata, size_r, lane_r, unsigned_r);
                end
                ST_WRITE: rdata_r <= 32'h0000_0000;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: directed cases followed by random traffic vs. a reference model.
module tb_lsu_mem_adapter;
    localparam int ADDR_WORDS = 256;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_init;
    int   tests = 0;
    int   fails = 0;

    lsu_mem_adapter_if bus();
    logic [31:0] mem     [ADDR_WORDS];
    logic [31:0] ref_mem [ADDR_WORDS];

    lsu_mem_adapter #(.ADDR_WORDS(ADDR_WORDS)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Data memory: combinational read, write on the clock edge.
    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < ADDR_WORDS; i++) mem[i] <= init_word(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction: model the expected outcome, drive, observe, compare.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] widx, word, v, nw, mask, exp_rd;
        logic        exp_err, mis, illegal;
        int          off, sh, exp_lat, exp_wr;
        int          lat, nwr, we_cyc, bad_ready;
        logic [31:0] obs_rd, wr_addr, wr_data;
        logic        obs_err;

        widx    = {2'b00, addr[31:2]};
        off     = int'(addr[1:0]);
        mis     = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
        illegal = (size == 2'd3) || (widx >= 32'(ADDR_WORDS)) || (TRAP_EN && mis);
        word    = illegal ? 32'h0 : ref_mem[widx[7:0]];
        nw      = 32'h0;
        exp_rd  = 32'h0;
        exp_err = 1'b0;
        exp_wr  = 0;
        if (illegal) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (!we) begin
            exp_lat = 2;
            if (size == 2'd0) begin
                v = (word >> (8 * off)) & 32'hFF;
                if (!uns && v[7]) v = v | 32'hFFFF_FF00;
            end else if (size == 2'd1) begin
                v = (word >> (16 * (off / 2))) & 32'hFFFF;
                if (!uns && v[15]) v = v | 32'hFFFF_0000;
            end else begin
                v = word;
            end
            exp_rd = v;
        end else if (size == 2'd2) begin
            exp_lat = 2;
            exp_wr  = 1;
            nw      = wdata;
        end else begin
            exp_lat = 3;
            exp_wr  = 1;
            sh      = (size == 2'd0) ? 8 * off : 16 * (off / 2);
            mask    = ((size == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            nw      = (word & ~mask) | ((wdata << sh) & mask);
        end

        check({tag, ".ready_idle"}, {31'h0, bus.req_ready}, 32'h1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = $urandom;
        bus.req_wdata    = $urandom;

        lat = 0; nwr = 0; we_cyc = 0; bad_ready = 0;
        obs_rd = 32'h0; obs_err = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.req_ready) bad_ready++;
            if (bus.mem_we) begin
                nwr++;
                we_cyc  = k;
                wr_addr = bus.mem_addr;
                wr_data = bus.mem_wdata;
            end
            if (bus.resp_valid) begin
                lat     = k;
                obs_rd  = bus.resp_rdata;
                obs_err = bus.resp_err;
            end
        end
        check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        check({tag, ".err"}, {31'h0, obs_err}, {31'h0, exp_err});
        check({tag, ".rdata"}, obs_rd, exp_rd);
        check({tag, ".ready_busy"}, 32'(bad_ready), 32'h0);
        check({tag, ".writes"}, 32'(nwr), 32'(exp_wr));
        if (exp_wr == 1) begin
            check({tag, ".wr_cycle"}, 32'(we_cyc), 32'(exp_lat - 1));
            check({tag, ".wr_addr"}, wr_addr, widx);
            check({tag, ".wr_data"}, wr_data, nw);
            ref_mem[widx[7:0]] = nw;
        end

        @(negedge clk);
        check({tag, ".ready_after"}, {31'h0, bus.req_ready}, 32'h1);
        check({tag, ".rdata_hold"}, bus.resp_rdata, exp_rd);
        check({tag, ".idle_bus"}, bus.mem_addr | bus.mem_wdata | {31'h0, bus.mem_we | bus.resp_valid}, 32'h0);
    endtask

    initial begin
        int bad;
        logic [1:0]  sz;
        logic [31:0] ad;
        int          r;

        rst = 1'b0;
        mem_init = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        for (int i = 0; i < ADDR_WORDS; i++) ref_mem[i] = init_word(i);
        #2 rst = 1'b1;
        #1;
        check("reset.ready", {31'h0, bus.req_ready}, 32'h1);
        check("reset.resp", {30'h0, bus.resp_valid, bus.resp_err}, 32'h0);
        check("reset.rdata", bus.resp_rdata, 32'h0);
        check("reset.mem", bus.mem_addr | bus.mem_wdata | {31'h0, bus.mem_we}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mem_init = 1'b0;

        // Directed scenarios.
        do_req("sw_0x10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        do_req("lw_0x10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req("sw_80ff", 1'b1, 2'd2, 1'b0, 32'h10, 32'h0000_80FF);
        do_req("lb_0x10", 1'b0, 2'd0, 1'b0, 32'h10, 32'h0);
        do_req("lbu_0x10", 1'b0, 2'd0, 1'b1, 32'h10, 32'h0);
        do_req("lh_0x10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
        do_req("lhu_0x12", 1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
        do_req("sw_1122", 1'b1, 2'd2, 1'b0, 32'h10, 32'h1122_3344);
        do_req("sb_0x13", 1'b1, 2'd0, 1'b0, 32'h13, 32'h0000_00AA);
        do_req("sh_0x12", 1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF_5566);
        do_req("size11", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
        do_req("st_size11", 1'b1, 2'd3, 1'b0, 32'h10, 32'h1234_5678);
        do_req("oob_0x400", 1'b1, 2'd2, 1'b0, 32'h400, 32'h1234_5678);
        do_req("lw_0x3fc", 1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0);
        do_req("lw_0x11", 1'b0, 2'd2, 1'b0, 32'h11, 32'h0);
        do_req("sh_0x15", 1'b1, 2'd1, 1'b0, 32'h15, 32'h0000_BEEF);

        // Reset in the READ phase of a sub-word store aborts it.
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0; bus.req_addr = 32'h10; bus.req_wdata = 32'h0000_0077;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort.read_addr", bus.mem_addr, 32'h4);
        rst = 1'b1;
        #1;
        check("abort.ready", {31'h0, bus.req_ready}, 32'h1);
        check("abort.outputs", {30'h0, bus.mem_we, bus.resp_valid} | bus.mem_addr | bus.resp_rdata, 32'h0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.mem_we || bus.resp_valid) bad++;
        end
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.mem_we || bus.resp_valid) bad++;
        end
        check("abort.quiet", 32'(bad), 32'h0);
        do_req("after_abort_lw", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);

        // Random traffic.
        for (int n = 0; n < 200; n++) begin
            r  = int'($urandom_range(0, 9));
            sz = (r < 9) ? 2'(r % 3) : 2'd3;
            r  = int'($urandom_range(0, 15));
            if (r == 0)      ad = $urandom;
            else if (r == 1) ad = 32'h400 + $urandom_range(0, 255);
            else             ad = $urandom_range(0, 1023);
            do_req("rand", 1'($urandom), sz, 1'($urandom), ad, $urandom);
        end

        bad = 0;
        for (int i = 0; i < ADDR_WORDS; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_final", 32'(bad), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/lsu_mem_adapter.md
LSU_MEM_ADAPTER -- requirements
Module: lsu_mem_adapter

Interface
REQ-001 Parameter: ADDR_WORDS, default 256, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  core load/store request present.
REQ-005 req_ready  output  1  adapter can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  extended load data, valid with resp_valid.
REQ-013 resp_err  output  1  request faulted, valid with resp_valid.
REQ-014 mem_addr  output  32  word index to data memory = {2'b00, byte_addr[31:2]}.
REQ-015 mem_wdata  output  32  full word written to memory.
REQ-016 mem_we  output  1  memory write enable.
REQ-017 mem_rdata  input  32  combinational read data from memory at mem_addr.

Function
REQ-018 FSM states: IDLE, READ, WRITE, DONE; req_ready = 1 only in IDLE.
REQ-019 Handshake: request accepted on the rising edge where req_valid && req_ready; all req_* fields are latched at acceptance and ignored afterwards.
REQ-020 Load: IDLE -> READ -> DONE. In READ, mem_addr = latched word index and mem_rdata is captured. resp_valid is high in DONE, 2 cycles after acceptance.
REQ-021 Load extraction: byte lane = addr[1:0], half lane = addr[1]; result is sign- or zero-extended per req_unsigned. Word loads ignore req_unsigned.
REQ-022 Word store: IDLE -> WRITE -> DONE. mem_we = 1 for exactly the WRITE cycle, with mem_wdata = req_wdata.
REQ-023 Sub-word store (read-modify-write): IDLE -> READ -> WRITE -> DONE. The READ capture is merged so only the addressed byte/half lanes are replaced.
REQ-024 Illegal: size 11 or word index >= ADDR_WORDS gives IDLE -> DONE with resp_err = 1, no READ/WRITE, mem_we never asserted.
REQ-025 DONE -> IDLE unconditionally. A new request may be accepted the cycle after DONE.
REQ-026 resp_rdata holds its last value outside DONE. It is 0 in DONE for stores and errored requests.
REQ-027 mem_we = 0 in every state except WRITE. mem_addr = 0 and mem_wdata = 0 in IDLE.

Reset
REQ-028 rst asserted: state = IDLE immediately, with req_ready = 1, resp_valid = 0, resp_err = 0, resp_rdata = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
REQ-029 rst during READ/WRITE aborts the request. No write occurs after rst rises, and no resp_valid is issued for the aborted request.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN defined: a half with addr[0] != 0, or a word with addr[1:0] != 0, is an error handled per REQ-024.
REQ-031 Macro LSU_MISALIGN_TRAP_EN undefined: the offending low address bits are treated as 0 (access aligned down) and no error is raised.

Verification
REQ-032 Word store addr 0x10, wdata 0xDEADBEEF: mem_we high 1 cycle with mem_addr 4; resp_valid 2 cycles after accept, resp_err 0.
REQ-033 With mem word 4 = 0x000080FF: lb at 0x10 -> 0xFFFFFFFF; lbu -> 0x000000FF; lh at 0x10 -> 0xFFFF80FF; lhu at 0x12 -> 0x00000000.
REQ-034 Word 4 = 0x11223344, sb 0xAA at 0x13: mem_wdata = 0xAA223344, mem_we in cycle 2 after accept, resp_valid in cycle 3.
REQ-035 req_size 11, or addr 0x400 with ADDR_WORDS 256: resp_valid and resp_err 1 cycle after accept, mem_we never high.
REQ-036 lw at 0x11: with LSU_MISALIGN_TRAP_EN -> resp_err 1, no access; without it -> reads word 4, resp_err 0.
REQ-037 Assert rst in READ of an sb: mem_we stays 0, no resp_valid, req_ready 1 immediately; the next request completes normally.
